insfetch: RTL and testbench
===========================

// Module: insfetch
// PURPOSE
//  Fetch stage for the barrel-threaded core; feeds the fetch/dec pipeline register consumed by insdec.
//  - Holds one PC per hardware thread and picks one active thread per cycle, round-robin.
//  - Reads that thread's instruction from the instruction memory and registers ins/trd/pc for decode.
//  - Owns thread lifetime: spawn, kill, and redirect on jump.
//  - Publishes new_trd_id, the thread id that decode initialises on a spawn.
// PARAMETERS
//  NUM_TRD   8       hardware threads; ids are 3 bits, so NUM_TRD is at most 8
//  RESET_PC  32'h0   PC loaded into thread 0 at reset
//  PC_STEP   4       PC increment per fetched instruction
// PORTS
//  clk          in   1   core clock
//  rst_n        in   1   asynchronous active-low reset
//  stall        in   1   hold the fetch/dec register and the round-robin pointer
//  imem_addr    out  32  combinational fetch address (PC of the selected thread)
//  imem_data    in   32  instruction at imem_addr, valid in the same cycle
//  jmp_en       in   1   redirect request from exe
//  jmp_trd      in   3   thread to redirect
//  jmp_pc       in   32  redirect target
//  spawn_en     in   1   start a new thread
//  spawn_pc     in   32  start PC of the new thread
//  kill_en      in   1   stop a thread
//  kill_trd     in   3   thread to stop
//  ins_dec      out  32  registered instruction to decode
//  trd_dec      out  3   registered thread id of ins_dec
//  pc_dec       out  32  registered PC of ins_dec
//  new_trd_id   out  3   lowest inactive thread id (combinational); 0 when trd_full
//  trd_full     out  1   all NUM_TRD threads active
//  active_mask  out  8   per-thread active bits; bits >= NUM_TRD tie to 0
//  idle         out  1   no active thread this cycle
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - active_mask=8'h01; pc[0]=RESET_PC; pc[others]=0; round-robin pointer=NUM_TRD-1.
//  - ins_dec=0 (NOP), trd_dec=0, pc_dec=0. Derived outputs: new_trd_id=1, trd_full=0, idle=0.
//  Select:
//  - sel = first active thread strictly after the pointer, cyclically; imem_addr = pc[sel].
//  - No active thread: idle=1, imem_addr=0, the register loads NOP with trd=0 and pc=0.
//  Advance (stall=0, a thread selected, sel not killed this cycle):
//  - Register loads {imem_data, sel, pc[sel]}.
//  - pc[sel] += PC_STEP, wrapping mod 2^32; pointer <= sel.
//  - Fetch latency is one cycle, address to ins_dec.
//  Redirect (jmp_en):
//  - pc[jmp_trd] <= jmp_pc; this beats the increment when jmp_trd == sel.
//  - If jmp_trd == sel, the register loads NOP (trd=sel, pc=0) instead of imem_data.
//  - If stall=1 and trd_dec == jmp_trd, the held entry becomes NOP regardless of stall.
//  - A redirect to an inactive thread updates its PC only.
//  Spawn (spawn_en, trd_full=0):
//  - active[new_trd_id] <= 1; pc[new_trd_id] <= spawn_pc. Eligible for selection from the next cycle.
//  - spawn_en with trd_full=1 is ignored, with no state change.
//  Kill (kill_en):
//  - active[kill_trd] <= 0. If kill_trd == sel, the register loads NOP and the pointer still advances.
//  - Killing an inactive thread is a no-op.
//  Simultaneous events:
//  - Kill and spawn in one cycle: new_trd_id is computed from the pre-kill mask, so the killed slot is not reused that cycle.
//  - Kill and jmp on the same thread: the kill wins the active bit; the PC still takes jmp_pc.
//  Stall:
//  - The register and the pointer hold; PCs hold except for a redirect target.
//  - active_mask still updates on spawn and kill.
//  Reset asserted mid-operation returns everything to the reset state asynchronously; in-flight fetch is discarded.
// CONFIGURATION
//  INSFETCH_PERF_EN defined:
//  - Adds output perf_fetch_cnt[31:0], reset to 0.
//  - Increments once per cycle in which the register loads a real (non-NOP) instruction; wraps at 2^32.
//  INSFETCH_PERF_EN undefined: the port and the counter are absent. All other behaviour is identical.
// STRUCTURE
//  Shared package kraken_pkg:
//  - TRD_W=3, NOP=32'h0.
//  - typedef logic [TRD_W-1:0] trd_id_t.
//  - Lowest-free-id function.
//  Sub-module trd_rr_arb:
//  - Inputs: active mask, pointer.
//  - Outputs: sel, none-active.
//  - Purely combinational; the pointer lives in insfetch.
// TESTING
//  1. Reset, no other stimulus, imem_data=addr -> thread 0 fetches 0,4,8; trd_dec=0 each cycle; new_trd_id=1.
//  2. spawn_en with spawn_pc=32'h100 -> active_mask=8'h03; fetch alternates trd 0/1 with PCs 12,0x100,16,0x104.
//  3. Spawn until all 8 active, then spawn again -> trd_full=1, new_trd_id=0, mask stays 8'hFF, order 0..7 cyclic.
//  4. jmp_en with jmp_trd=sel and jmp_pc=32'h40 -> ins_dec=NOP that cycle; that thread's next fetch has pc_dec=0x40.
//  5. Same-cycle kill of thread 1 and spawn -> new_trd_id=2 is taken and thread 1 goes inactive; the next spawn gets id 1.
//  6. stall=1 for 3 cycles, with a jmp on trd_dec in cycle 2 -> outputs hold, then show NOP; after release, round-robin resumes after the held thread.
//  7. INSFETCH_PERF_EN defined: 10 cycles of fetch containing 2 NOP cycles -> perf_fetch_cnt=8.

Source files
------------

// File: rtl/kraken_pkg.sv
// Shared thread-id types and helpers for the barrel-threaded core.
package kraken_pkg;

    localparam int          TRD_W = 3;
    localparam logic [31:0] NOP   = 32'h0;

    typedef logic [TRD_W-1:0] trd_id_t;

    // busy has a 1 for every occupied (or nonexistent) slot; returns 0 when none is free
    function automatic trd_id_t lowest_free(input logic [7:0] busy);
        trd_id_t id;
        id = '0;
        for (int i = 7; i >= 0; i--) begin
            if (!busy[i]) id = trd_id_t'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/trd_rr_arb.sv
// Round-robin thread picker: first active thread strictly after ptr, cyclically.
module trd_rr_arb import kraken_pkg::*; #(
    parameter int NUM_TRD = 8
) (
    input  logic [7:0] active,
    input  trd_id_t    ptr,
    output trd_id_t    sel,
    output logic       none
);

    int idx;

    // Scan from the farthest offset down so the nearest active thread wins;
    // offset NUM_TRD lands on ptr itself, so a lone thread keeps running.
    always_comb begin
        sel  = '0;
        none = 1'b1;
        idx  = 0;
        for (int off = NUM_TRD; off >= 1; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_TRD) idx = idx - NUM_TRD;
            if (active[idx[2:0]]) begin
                sel  = trd_id_t'(idx);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/insfetch.sv
// Fetch stage: per-thread PCs, round-robin thread select, thread spawn/kill/redirect.
// Optional INSFETCH_PERF_EN adds perf_fetch_cnt, counting real instructions loaded.
module insfetch import kraken_pkg::*; #(
    parameter int          NUM_TRD  = 8,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        jmp_en,
    input  trd_id_t     jmp_trd,
    input  logic [31:0] jmp_pc,
    input  logic        spawn_en,
    input  logic [31:0] spawn_pc,
    input  logic        kill_en,
    input  trd_id_t     kill_trd,
    output logic [31:0] ins_dec,
    output trd_id_t     trd_dec,
    output logic [31:0] pc_dec,
    output trd_id_t     new_trd_id,
    output logic        trd_full,
    output logic [7:0]  active_mask,
    output logic        idle
`ifdef INSFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt
`endif
);

    localparam logic [8:0] VALID9    = (9'd1 << NUM_TRD) - 9'd1;
    localparam logic [7:0] TRD_VALID = VALID9[7:0];

    logic [NUM_TRD-1:0][31:0] pc;
    trd_id_t    ptr, sel;
    logic       none;
    logic [7:0] busy, spawn_bit, kill_bit;
    logic       spawn_ok, kill_hit, jmp_hit, adv, load_ins;

    // Nonexistent slots count as busy so they are never handed out
    assign busy       = active_mask | ~TRD_VALID;
    assign trd_full   = &busy;
    assign new_trd_id = lowest_free(busy);

    trd_rr_arb #(.NUM_TRD(NUM_TRD)) u_arb (
        .active (active_mask),
        .ptr    (ptr),
        .sel    (sel),
        .none   (none)
    );

    assign idle      = none;
    assign imem_addr = none ? 32'h0 : pc[sel];

    assign spawn_ok  = spawn_en && !trd_full;
    assign spawn_bit = spawn_ok ? (8'h01 << new_trd_id) : 8'h00;
    assign kill_bit  = kill_en ? ((8'h01 << kill_trd) & TRD_VALID) : 8'h00;
    assign kill_hit  = kill_en && !none && (kill_trd == sel);
    assign jmp_hit   = jmp_en && !none && (jmp_trd == sel);
    assign adv       = !stall && !none;
    assign load_ins  = adv && !kill_hit && !jmp_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_mask <= 8'h01;
            ptr         <= trd_id_t'(NUM_TRD - 1);
            ins_dec     <= NOP;
            trd_dec     <= '0;
            pc_dec      <= '0;
        end else begin
            // kill applies first so a same-cycle spawn into a free slot is kept
            active_mask <= (active_mask & ~kill_bit) | spawn_bit;
            if (adv) begin
                ptr     <= sel;
                trd_dec <= sel;
                ins_dec <= load_ins ? imem_data : NOP;
                pc_dec  <= load_ins ? pc[sel] : 32'h0;
            end else if (!stall) begin
                ins_dec <= NOP;
                trd_dec <= '0;
                pc_dec  <= '0;
            end else if (jmp_en && (jmp_trd == trd_dec)) begin
                ins_dec <= NOP;
                pc_dec  <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            pc[0] <= RESET_PC;
        end else begin
            for (int i = 0; i < NUM_TRD; i++) begin
                if (spawn_ok && (new_trd_id == trd_id_t'(i)))
                    pc[i] <= spawn_pc;
                else if (jmp_en && (jmp_trd == trd_id_t'(i)))
                    pc[i] <= jmp_pc;
                else if (load_ins && (sel == trd_id_t'(i)))
                    pc[i] <= pc[i] + 32'(PC_STEP);
            end
        end
    end

`ifdef INSFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        perf_fetch_cnt <= '0;
        else if (load_ins) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_insfetch.sv
// Scoreboard bench for insfetch: expected decode entries are queued per cycle and popped after the edge.
module tb_insfetch;

    localparam logic [31:0] M = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n, stall;
    logic [31:0] imem_addr, imem_data;
    logic        jmp_en;
    logic [2:0]  jmp_trd;
    logic [31:0] jmp_pc;
    logic        spawn_en;
    logic [31:0] spawn_pc;
    logic        kill_en;
    logic [2:0]  kill_trd;
    logic [31:0] ins_dec;
    logic [2:0]  trd_dec;
    logic [31:0] pc_dec;
    logic [2:0]  new_trd_id;
    logic        trd_full;
    logic [7:0]  active_mask;
    logic        idle;
`ifdef INSFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf0;
`endif

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  trd;
        logic [31:0] pc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] epc [8];
    logic [31:0] hold;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Memory returns the address with the top bit set so real fetches never look like NOP
    assign imem_data = imem_addr | M;

    always #5 clk = ~clk;

    insfetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .jmp_en      (jmp_en),
        .jmp_trd     (jmp_trd),
        .jmp_pc      (jmp_pc),
        .spawn_en    (spawn_en),
        .spawn_pc    (spawn_pc),
        .kill_en     (kill_en),
        .kill_trd    (kill_trd),
        .ins_dec     (ins_dec),
        .trd_dec     (trd_dec),
        .pc_dec      (pc_dec),
        .new_trd_id  (new_trd_id),
        .trd_full    (trd_full),
        .active_mask (active_mask),
        .idle        (idle)
`ifdef INSFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [31:0] ei, input logic [2:0] et,
                       input logic [31:0] ep);
        exp_t e;
        sbq.push_back('{ins: ei, trd: et, pc: ep});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({tag, ".ins"}, ins_dec, e.ins);
        chk({tag, ".trd"}, 32'(trd_dec), 32'(e.trd));
        chk({tag, ".pc"},  pc_dec, e.pc);
    endtask

    task automatic fetch(input string tag, input int t);
        cyc(tag, epc[t] | M, 3'(t), epc[t]);
        epc[t] = epc[t] + 32'd4;
    endtask

    task automatic nop(input string tag, input int t);
        cyc(tag, 32'h0, 3'(t), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        jmp_en = 1'b0; jmp_trd = '0; jmp_pc = '0;
        spawn_en = 1'b0; spawn_pc = '0;
        kill_en = 1'b0; kill_trd = '0;
        for (int i = 0; i < 8; i++) epc[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ins", ins_dec, 32'h0);
        chk("rst.pc", pc_dec, 32'h0);
        chk("rst.mask", 32'(active_mask), 32'h01);
        chk("rst.new_id", 32'(new_trd_id), 32'd1);
        chk("rst.full", 32'(trd_full), 32'd0);
        chk("rst.idle", 32'(idle), 32'd0);
        chk("rst.addr", imem_addr, 32'h0);
        rst_n = 1'b1;

        // single thread walks 0,4,8
        for (int k = 0; k < 3; k++) fetch("t1", 0);

        // spawn thread 1, then alternate
        spawn_en = 1'b1; spawn_pc = 32'h100; #1;
        chk("t2.new_id", 32'(new_trd_id), 32'd1);
        fetch("t2.a", 0);
        epc[1] = 32'h100;
        spawn_en = 1'b0; #1;
        chk("t2.mask", 32'(active_mask), 32'h03);
        fetch("t2.b", 1); fetch("t2.c", 0); fetch("t2.d", 1);

        // kill 1 and spawn together: slot 2 taken, slot 1 freed for the next spawn
        kill_en = 1'b1; kill_trd = 3'd1; spawn_en = 1'b1; spawn_pc = 32'h300; #1;
        chk("t5.new_id", 32'(new_trd_id), 32'd2);
        fetch("t5.a", 0);
        epc[2] = 32'h300;
        kill_en = 1'b0; spawn_pc = 32'h400; #1;
        chk("t5.mask", 32'(active_mask), 32'h05);
        chk("t5.new_id2", 32'(new_trd_id), 32'd1);
        fetch("t5.b", 2);
        epc[1] = 32'h400;

        // fill the remaining slots 3..7
        for (int k = 3; k < 8; k++) begin
            spawn_pc = 32'(k) << 12; #1;
            chk("t3.new_id", 32'(new_trd_id), 32'(k));
            epc[k] = 32'(k) << 12;
            fetch("t3.fill", k - 3);
        end
        #1;
        chk("t3.full", 32'(trd_full), 32'd1);
        chk("t3.new_id0", 32'(new_trd_id), 32'd0);
        fetch("t3.ovf", 5);
        spawn_en = 1'b0; #1;
        chk("t3.mask", 32'(active_mask), 32'hFF);
        for (int k = 0; k < 8; k++) fetch("t3.rr", (6 + k) % 8);

        // redirect the thread being selected
        jmp_en = 1'b1; jmp_trd = 3'd6; jmp_pc = 32'h40; #1;
        chk("t4.addr", imem_addr, epc[6]);
        nop("t4.nop", 6);
        epc[6] = 32'h40;
        jmp_en = 1'b0;
        for (int k = 0; k < 8; k++) fetch("t4.rr", (7 + k) % 8);

        // kill the thread being selected; pointer still moves on
        kill_en = 1'b1; kill_trd = 3'd7;
        nop("kill.nop", 7);
        kill_en = 1'b0; #1;
        chk("kill.mask", 32'(active_mask), 32'h7F);
        chk("kill.new_id", 32'(new_trd_id), 32'd7);
        fetch("kill.a", 0); fetch("kill.b", 1);

        // stall three cycles with a redirect on the held thread in the middle
        hold = epc[1] - 32'd4;
        stall = 1'b1;
        cyc("t6.hold", hold | M, 3'd1, hold);
        jmp_en = 1'b1; jmp_trd = 3'd1; jmp_pc = 32'h80;
        nop("t6.jmp", 1);
        jmp_en = 1'b0; #1;
        chk("t6.addr", imem_addr, epc[2]);
        nop("t6.held", 1);
        epc[1] = 32'h80;
        stall = 1'b0;
        for (int k = 0; k < 7; k++) fetch("t6.rr", (k < 5) ? (2 + k) : (k - 5));

        // asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0; #1;
        chk("arst.ins", ins_dec, 32'h0);
        chk("arst.pc", pc_dec, 32'h0);
        chk("arst.mask", 32'(active_mask), 32'h01);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) epc[i] = 32'h0;

        // kill the only thread: core goes idle
        kill_en = 1'b1; kill_trd = 3'd0;
        nop("idle.kill", 0);
        kill_en = 1'b0; #1;
        chk("idle.idle", 32'(idle), 32'd1);
        chk("idle.addr", imem_addr, 32'h0);
        chk("idle.mask", 32'(active_mask), 32'h00);
        chk("idle.new_id", 32'(new_trd_id), 32'd0);
        spawn_en = 1'b1; spawn_pc = 32'h500;
        nop("idle.nop", 0);
        spawn_en = 1'b0;
        epc[0] = 32'h500;

        // ten cycles, two of them redirect NOPs
`ifdef INSFETCH_PERF_EN
        perf0 = perf_fetch_cnt;
`endif
        for (int k = 0; k < 4; k++) fetch("perf.a", 0);
        jmp_en = 1'b1; jmp_trd = 3'd0; jmp_pc = 32'h600;
        nop("perf.j1", 0);
        epc[0] = 32'h600; jmp_en = 1'b0;
        for (int k = 0; k < 3; k++) fetch("perf.b", 0);
        jmp_en = 1'b1; jmp_pc = 32'h700;
        nop("perf.j2", 0);
        epc[0] = 32'h700; jmp_en = 1'b0;
        fetch("perf.c", 0);
`ifdef INSFETCH_PERF_EN
        chk("perf.cnt", perf_fetch_cnt - perf0, 32'd8);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
